// File: rtl/axi4_lite_reg_slave.sv
// axi4_lite_reg_slave
//   AXI4-Lite slave exposing REG_COUNT registers of DATA_WIDTH bits. AW and W
//   are captured independently. Writes honour byte strobes. Registers selected
//   by RO_MASK are read-only and return hw_val_i. AxPROT privilege and security
//   checks are applied, and OKAY/SLVERR/DECERR responses are generated.
//   DATA_WIDTH must be 32 or 64. BASE_ADDR must be aligned to DATA_WIDTH/8.
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   aw*/w*/b*               write address, write data, write response channels
//   ar*/r*                  read address and read data channels
//   regs_o                  register contents, register i at slice i
//                           (RO slices show hw_val_i registered once)
//   wr_pulse_o              one-cycle strobe per successful register write
//   hw_val_i                read value for read-only registers
module axi4_lite_reg_slave #(
    parameter int unsigned            ADDR_WIDTH         = 16,
    parameter int unsigned            DATA_WIDTH         = 32,
    parameter int unsigned            REG_COUNT          = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR          = '0,
    parameter logic [REG_COUNT-1:0]   RO_MASK            = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE        = '0,
    parameter bit                     REQUIRE_PRIVILEGED = 1'b0,
    parameter bit                     REQUIRE_SECURE     = 1'b0
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [ADDR_WIDTH-1:0]           awaddr,
    input  logic [2:0]                      awprot,
    input  logic                            awvalid,
    output logic                            awready,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [DATA_WIDTH/8-1:0]         wstrb,
    input  logic                            wvalid,
    output logic                            wready,
    output logic [1:0]                      bresp,
    output logic                            bvalid,
    input  logic                            bready,
    input  logic [ADDR_WIDTH-1:0]           araddr,
    input  logic [2:0]                      arprot,
    input  logic                            arvalid,
    output logic                            arready,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [1:0]                      rresp,
    output logic                            rvalid,
    input  logic                            rready,
    output logic [REG_COUNT*DATA_WIDTH-1:0] regs_o,
    output logic [REG_COUNT-1:0]            wr_pulse_o,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] hw_val_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_W      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Returns {hit, idx}. The low byte-offset bits drop out in the shift.
    function automatic logic [IDX_W:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        logic                  hit;
        word = (addr - BASE_ADDR) >> ADDR_LSB;
        hit  = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(REG_COUNT));
        return {hit, word[IDX_W-1:0]};
    endfunction

    function automatic logic is_ro(input logic [IDX_W-1:0] idx);
        logic ro;
        ro = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            ro = ro | (RO_MASK[i] & (idx == IDX_W'(i)));
        end
        return ro;
    endfunction

    // A miss wins over every other error. The protection check and the RO
    // check both map to SLVERR.
    function automatic logic [1:0] access_resp(input logic hit, input logic [1:0] prot,
                                               input logic ro, input logic is_wr);
        logic [1:0] resp;
        if (!hit) begin
            resp = RESP_DECERR;
        end else if ((REQUIRE_PRIVILEGED && !prot[0]) || (REQUIRE_SECURE && prot[1]) ||
                     (is_wr && ro)) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

    w_state_e                  w_state_q, w_state_d;
    r_state_e                  r_state_q, r_state_d;
    logic                      awready_q, awready_d, wready_q, wready_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [1:0]                awprot_q, awprot_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [REG_COUNT-1:0]      wr_pulse_q, wr_pulse_d;
    logic                      arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]     regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]     regs_d [REG_COUNT];

    // Prot bit 2 (instruction/data) carries no meaning for a register bank.
    logic unused_prot_s;
    assign unused_prot_s = awprot[2] ^ arprot[2];

    // While awready/wready are still high nothing is captured yet, so the live
    // channel is used. This lets a same-cycle AW+W commit on its handshake edge.
    logic                  have_aw_s, have_w_s, wr_commit_s, wr_ok_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [1:0]            wr_prot_s, wr_resp_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [STRB_WIDTH-1:0] wr_strb_s;
    logic [IDX_W:0]        wr_dec_s, rd_dec_s;
    logic [1:0]            rd_resp_s;
    logic [DATA_WIDTH-1:0] rd_val_s;

    assign have_aw_s   = !awready_q || awvalid;
    assign have_w_s    = !wready_q || wvalid;
    assign wr_addr_s   = awready_q ? awaddr : awaddr_q;
    assign wr_prot_s   = awready_q ? awprot[1:0] : awprot_q;
    assign wr_data_s   = wready_q ? wdata : wdata_q;
    assign wr_strb_s   = wready_q ? wstrb : wstrb_q;
    assign wr_dec_s    = decode(wr_addr_s);
    assign wr_resp_s   = access_resp(wr_dec_s[IDX_W], wr_prot_s, is_ro(wr_dec_s[IDX_W-1:0]), 1'b1);
    assign wr_commit_s = (w_state_q == W_IDLE) && have_aw_s && have_w_s;
    assign wr_ok_s     = wr_commit_s && (wr_resp_s == RESP_OKAY);

    // Write channel FSM: capture AW/W independently, then hold B until bready.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        awaddr_d  = awaddr_q;
        awprot_d  = awprot_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    awaddr_d  = awaddr;
                    awprot_d  = awprot[1:0];
                    awready_d = 1'b0;
                end else begin
                    awaddr_d  = awaddr_q;
                end
                if (wvalid && wready_q) begin
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                    wready_d = 1'b0;
                end else begin
                    wdata_d  = wdata_q;
                end
                if (wr_commit_s) begin
                    w_state_d = W_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_resp_s;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                wready_d  = 1'b1;
            end
        endcase
    end

    // Register next-state: RO slots track hw_val_i, and writable slots take
    // the strobed bytes of an OKAY write.
    always_comb begin
        wr_pulse_d = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_d[i]     = RO_MASK[i] ? hw_val_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            wr_pulse_d[i] = wr_ok_s && (wr_dec_s[IDX_W-1:0] == IDX_W'(i));
            for (int b = 0; b < STRB_WIDTH; b++) begin
                regs_d[i][b*8 +: 8] = (wr_pulse_d[i] && wr_strb_s[b]) ?
                                      wr_data_s[b*8 +: 8] : regs_d[i][b*8 +: 8];
            end
        end
    end

    assign rd_dec_s  = decode(araddr);
    assign rd_resp_s = access_resp(rd_dec_s[IDX_W], arprot[1:0], is_ro(rd_dec_s[IDX_W-1:0]), 1'b0);

    // Read mux uses regs_q, so a same-edge write is never visible to the read.
    always_comb begin
        rd_val_s = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            rd_val_s = (rd_dec_s[IDX_W-1:0] == IDX_W'(i)) ?
                       (RO_MASK[i] ? hw_val_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i]) : rd_val_s;
        end
    end

    // Read channel FSM: one-cycle latency, R held until rready.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = rd_resp_s;
                    rdata_d   = (rd_resp_s == RESP_OKAY) ? rd_val_s : {DATA_WIDTH{1'b0}};
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            arready_q  <= 1'b1;
            awaddr_q   <= '0;
            awprot_q   <= 2'b00;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            awaddr_q   <= awaddr_d;
            awprot_q   <= awprot_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign awready    = awready_q;
    assign wready     = wready_q;
    assign bvalid     = bvalid_q;
    assign bresp      = bresp_q;
    assign arready    = arready_q;
    assign rvalid     = rvalid_q;
    assign rresp      = rresp_q;
    assign rdata      = rdata_q;
    assign wr_pulse_o = wr_pulse_q;

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs_o
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave. B and R responses are predicted into
// queues when a transaction is issued. A monitor pops them on each handshake.
// The DUT uses BASE_ADDR=0x0100, RO_MASK=0x01 and REQUIRE_PRIVILEGED=1.
// Normal accesses therefore use prot=3'b001.
module tb_axi4_lite_reg_slave;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic         aclk, areset;
    logic [15:0]  awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] regs_o, hw_val_i;
    logic [7:0]   wr_pulse_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];

    axi4_lite_reg_slave #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .REG_COUNT(8),
        .BASE_ADDR(16'h0100), .RO_MASK(8'h01), .RESET_VALUE(32'h0000_0000),
        .REQUIRE_PRIVILEGED(1'b1), .REQUIRE_SECURE(1'b0)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .hw_val_i(hw_val_i)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_slice(input int i);
        return regs_o[i*32 +: 32];
    endfunction

    // Scoreboard monitor: compares on each B and R handshake cycle.
    always @(negedge aclk) begin
        if (!areset) begin
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) begin
                    check("unexpected_b", 64'(bresp), 64'hFFFF);
                end else begin
                    check("bresp", 64'(bresp), 64'(exp_b_q.pop_front()));
                end
            end
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) begin
                    check("unexpected_r", {30'h0, rresp, rdata}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    check("r_resp_data", {30'h0, rresp, rdata}, {30'h0, exp_r_q.pop_front()});
                end
            end
        end
    end

    // Called at the edge that committed a write. Checks the pulse over two
    // cycles, then completes the B handshake.
    task automatic finish_b(input logic [7:0] pulse);
        @(negedge aclk);
        check("bvalid_latency", 64'(bvalid), 64'd1);
        check("wr_pulse", 64'(wr_pulse_o), 64'(pulse));
        check("wready_held_low", 64'(wready), 64'd0);
        @(posedge aclk); #1; bready = 1'b1;
        @(negedge aclk);
        check("wr_pulse_one_cycle", 64'(wr_pulse_o), 64'd0);
        @(posedge aclk); #1; bready = 1'b0;
        @(negedge aclk);
        check("bvalid_cleared", 64'(bvalid), 64'd0);
        check("aw_w_ready_back", {awready, wready}, 64'h3);
    endtask

    task automatic write_same(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input logic [2:0] prot, input logic [1:0] resp, input logic [7:0] pulse);
        exp_b_q.push_back(resp);
        @(posedge aclk); #1;
        awaddr = addr; awprot = prot; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        finish_b(pulse);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [2:0] prot,
                           input logic [31:0] data, input logic [1:0] resp);
        exp_r_q.push_back({resp, data});
        @(posedge aclk); #1;
        araddr = addr; arprot = prot; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        check("rvalid_latency", {rvalid, arready}, 64'h2);
        @(posedge aclk); #1; rready = 1'b1;
        @(posedge aclk); #1; rready = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        hw_val_i = '0;
        hw_val_i[31:0]  = 32'hCAFE_0001;
        hw_val_i[63:32] = 32'h1111_0000;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_readies", {awready, wready, arready}, 64'h7);
        check("reset_valids", {bvalid, rvalid, wr_pulse_o}, 64'h0);
        check("reset_resp_data", {bresp, rresp, rdata}, 64'h0);
        check("reset_regs", 64'(regs_o[255:128] | regs_o[127:0]), 64'h0);
        @(posedge aclk); #1; areset = 1'b0;

        // Same-cycle AW+W to register 1
        write_same(16'h0104, 32'hDEAD_BEEF, 4'hF, 3'b001, OKAY, 8'h02);
        check("reg1_value", 64'(reg_slice(1)), 64'hDEAD_BEEF);
        write_same(16'h0108, 32'hAAAA_AAAA, 4'hF, 3'b001, OKAY, 8'h04);

        // W leads AW by three cycles, low half-word strobed
        exp_b_q.push_back(OKAY);
        @(posedge aclk); #1;
        wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
        @(posedge aclk); #1; wvalid = 1'b0;
        repeat (2) begin
            @(negedge aclk);
            check("wready_low_after_w", {wready, bvalid}, 64'h0);
            @(posedge aclk); #1;
        end
        awaddr = 16'h0108; awprot = 3'b001; awvalid = 1'b1;
        @(negedge aclk);
        check("wready_low_before_aw", 64'(wready), 64'd0);
        @(posedge aclk); #1; awvalid = 1'b0;
        finish_b(8'h04);
        check("reg2_strobed", 64'(reg_slice(2)), 64'hAAAA_5678);

        do_read(16'h0104, 3'b001, 32'hDEAD_BEEF, OKAY);
        do_read(16'h0108, 3'b001, 32'hAAAA_5678, OKAY);
        do_read(16'h0106, 3'b001, 32'hDEAD_BEEF, OKAY);   // byte offset ignored

        // Decode misses: past the last register and below the base
        do_read(16'h0120, 3'b001, 32'h0, DECERR);
        write_same(16'h0120, 32'h5A5A_5A5A, 4'hF, 3'b001, DECERR, 8'h00);
        do_read(16'h00FC, 3'b001, 32'h0, DECERR);
        write_same(16'h011C, 32'h7777_7777, 4'hF, 3'b001, OKAY, 8'h80);
        do_read(16'h011C, 3'b001, 32'h7777_7777, OKAY);

        // Privilege check
        write_same(16'h010C, 32'h1111_1111, 4'hF, 3'b000, SLVERR, 8'h00);
        check("reg3_unchanged", 64'(reg_slice(3)), 64'h0);
        write_same(16'h010C, 32'h1111_1111, 4'hF, 3'b001, OKAY, 8'h08);
        check("reg3_written", 64'(reg_slice(3)), 64'h1111_1111);
        do_read(16'h010C, 3'b000, 32'h0, SLVERR);
        write_same(16'h010C, 32'hFFFF_FFFF, 4'h0, 3'b001, OKAY, 8'h08);
        check("reg3_zero_strobe", 64'(reg_slice(3)), 64'h1111_1111);

        // Read-only register 0 backed by hw_val_i
        do_read(16'h0100, 3'b001, 32'hCAFE_0001, OKAY);
        write_same(16'h0100, 32'h0000_0000, 4'hF, 3'b001, SLVERR, 8'h00);

        // Read and write of register 1 on the same edge: read sees the old value
        exp_b_q.push_back(OKAY);
        exp_r_q.push_back({OKAY, 32'hDEAD_BEEF});
        @(posedge aclk); #1;
        awaddr = 16'h0104; awprot = 3'b001; awvalid = 1'b1;
        wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 16'h0104; arprot = 3'b001; arvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge aclk); #1; rready = 1'b1;
        finish_b(8'h00);
        rready = 1'b0;
        check("reg1_after_collision", 64'(reg_slice(1)), 64'h5555_5555);

        // Ten-cycle stall on both response channels
        exp_b_q.push_back(OKAY);
        exp_r_q.push_back({OKAY, 32'h5555_5555});
        @(posedge aclk); #1;
        awaddr = 16'h0110; awprot = 3'b001; awvalid = 1'b1;
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 16'h0104; arprot = 3'b001; arvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            check("stall_valids", {bvalid, rvalid, arready, awready}, 64'hC);
            check("stall_payload", {bresp, rresp, rdata}, {28'h0, OKAY, OKAY, 32'h5555_5555});
            @(posedge aclk); #1;
        end
        check("reg4_written", 64'(reg_slice(4)), 64'h0BAD_F00D);
        bready = 1'b1;
        @(posedge aclk); #1; bready = 1'b0;

        // Reset while R is still pending: the read is dropped
        void'(exp_r_q.pop_front());
        areset = 1'b1;
        #1;
        check("reset_mid_read", {rvalid, arready}, 64'h1);
        check("reset_regs_cleared", 64'(reg_slice(1) | reg_slice(2) | reg_slice(4)), 64'h0);
        @(posedge aclk); #1; areset = 1'b0;
        do_read(16'h0104, 3'b001, 32'h0, OKAY);
        do_read(16'h0100, 3'b001, 32'hCAFE_0001, OKAY);

        repeat (2) @(posedge aclk);
        check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
        check("r_queue_drained", 64'(exp_r_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
